// File: rtl/pll_rst_seq.sv
// PLL power-up and recovery sequencer. It holds the PLL in reset, qualifies lock
// with a bounded retry count, and releases the downstream reset domains in a fixed order.
module pll_rst_seq #(
    parameter int unsigned PLL_RST_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned LOCK_STABLE    = 64,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  pll_locked_in,
    input  logic                  restart_in,
    output logic                  pll_areset_out,
    output logic [NUM_STAGES-1:0] stage_rst_n_out,
    output logic                  sys_ready_out,
    output logic                  fault_out,
    output logic [3:0]            retry_cnt_out
);

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Saturating retry counter increment
    function automatic logic [3:0] retry_sat_inc(input logic [3:0] v);
        if (v == 4'hF) begin
            return v;
        end else begin
            return v + 4'h1;
        end
    endfunction

    // One shared counter serves every timed state, so it is sized for the largest interval.
    localparam int unsigned CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                             max_of(LOCK_STABLE, STAGE_GAP));
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]      RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] STAGE_FIRST  = NUM_STAGES'(1);
    localparam logic [3:0]            RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    logic                  r_lk_meta;
    logic                  r_lk;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pll_areset;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_sys_ready;
    logic                  r_fault;
    logic [3:0]            r_retry_cnt;

    logic                  w_stages_live;
    logic                  w_abort;
    logic [3:0]            w_retry_next;

    assign w_stages_live = (r_state == ST_RELEASE) || (r_state == ST_RUN);
    assign w_abort       = (r_state != ST_FAULT) && (restart_in || (w_stages_live && !r_lk));
    assign w_retry_next  = retry_sat_inc(r_retry_cnt);

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked_in;
            r_lk      <= r_lk_meta;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_PLL_RST;
            r_cnt         <= '0;
            r_pll_areset  <= 1'b1;
            r_stage_rst_n <= '0;
            r_sys_ready   <= 1'b0;
            r_fault       <= 1'b0;
            r_retry_cnt   <= 4'd0;
        end else if (w_abort) begin
            // Restart or lock loss: drop every domain at once and re-run from PLL reset.
            r_state       <= ST_PLL_RST;
            r_cnt         <= '0;
            r_pll_areset  <= 1'b1;
            r_stage_rst_n <= '0;
            r_sys_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    r_pll_areset <= 1'b1;
                    if (r_cnt == RST_LAST) begin
                        r_state      <= ST_WAIT_LOCK;
                        r_cnt        <= '0;
                        r_pll_areset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lk) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_retry_cnt  <= w_retry_next;
                        r_cnt        <= '0;
                        r_pll_areset <= 1'b1;
                        if (w_retry_next == RETRY_LIMIT) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= ST_PLL_RST;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!r_lk) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state       <= ST_RELEASE;
                        r_cnt         <= '0;
                        r_stage_rst_n <= STAGE_FIRST;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    // Stages fill from bit 0 upward, so release order cannot be violated.
                    if (r_stage_rst_n[NUM_STAGES-1]) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_sys_ready <= 1'b1;
                        r_retry_cnt <= 4'd0;
                    end else if (r_cnt == GAP_LAST) begin
                        r_cnt         <= '0;
                        r_stage_rst_n <= (r_stage_rst_n << 1'b1) | STAGE_FIRST;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    r_sys_ready <= 1'b1;
                end
                ST_FAULT: begin
                    r_pll_areset  <= 1'b1;
                    r_stage_rst_n <= '0;
                    r_sys_ready   <= 1'b0;
                    if (restart_in) begin
                        r_state     <= ST_PLL_RST;
                        r_cnt       <= '0;
                        r_fault     <= 1'b0;
                        r_retry_cnt <= 4'd0;
                    end else begin
                        r_fault <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_PLL_RST;
                    r_cnt         <= '0;
                    r_pll_areset  <= 1'b1;
                    r_stage_rst_n <= '0;
                    r_sys_ready   <= 1'b0;
                    r_fault       <= 1'b0;
                end
            endcase
        end
    end

    assign pll_areset_out  = r_pll_areset;
    assign stage_rst_n_out = r_stage_rst_n;
    assign sys_ready_out   = r_sys_ready;
    assign fault_out       = r_fault;
    assign retry_cnt_out   = r_retry_cnt;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: random lock timing against an event-time model derived
// from the sequencer's latency rules (sync delay, stable window, stage spacing, timeouts).
`timescale 1ns/1ps
module tb_pll_rst_seq;
    localparam int PRC = 4;
    localparam int LT  = 100;
    localparam int LS  = 16;
    localparam int NS  = 3;
    localparam int GAP = 8;
    localparam int MR  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lock;
    logic          restart;
    logic          pll_areset_out;
    logic [NS-1:0] stage_rst_n_out;
    logic          sys_ready_out;
    logic          fault_out;
    logic [3:0]    retry_cnt_out;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int g_w;
    int t_rise [NS];
    int t_ready;
    int r_at_b0;
    bit order_bad;

    pll_rst_seq #(
        .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
        .NUM_STAGES(NS), .STAGE_GAP(GAP), .MAX_RETRY(MR)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .pll_locked_in(lock), .restart_in(restart),
        .pll_areset_out(pll_areset_out), .stage_rst_n_out(stage_rst_n_out),
        .sys_ready_out(sys_ready_out), .fault_out(fault_out), .retry_cnt_out(retry_cnt_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Reference model: first stage release is limited either by lock arrival
    // (2 sync + 1 detect + LS qualify) or by PLL reset ending while already locked.
    function automatic int exp_bit0(input int w, input int l);
        int a;
        int b;
        a = l + 2 + 1 + LS;
        b = w + 1 + LS;
        return (a > b) ? a : b;
    endfunction

    function automatic int exp_stage(input int b0, input int k);
        return b0 + k * GAP;
    endfunction

    function automatic int exp_ready(input int b0);
        return b0 + (NS - 1) * GAP + 1;
    endfunction

    function automatic int exp_timeout(input int w, input int n);
        return w + LT + (n - 1) * (PRC + LT);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_areset_fall(input int budget, output int t_hi, output int t_lo, output bit ok);
        int n;
        n = 0;
        while (pll_areset_out !== 1'b1 && n < budget) begin tick(); n++; end
        t_hi = cyc;
        while (pll_areset_out !== 1'b0 && n < budget) begin tick(); n++; end
        t_lo = cyc;
        ok = (pll_areset_out === 1'b0);
    endtask

    task automatic observe_release(input int budget, output bit ok);
        for (int k = 0; k < NS; k++) t_rise[k] = -1;
        t_ready = -1;
        r_at_b0 = -1;
        order_bad = 1'b0;
        for (int i = 0; i < budget && t_ready < 0; i++) begin
            tick();
            for (int k = 0; k < NS; k++)
                if (t_rise[k] < 0 && stage_rst_n_out[k] === 1'b1) t_rise[k] = cyc;
            if (t_rise[0] == cyc) r_at_b0 = int'(retry_cnt_out);
            for (int k = 1; k < NS; k++)
                if (stage_rst_n_out[k] === 1'b1 && stage_rst_n_out[k-1] !== 1'b1) order_bad = 1'b1;
            if (sys_ready_out === 1'b1) t_ready = cyc;
        end
        ok = (t_ready >= 0);
    endtask

    task automatic test_reset();
        int t_hi, t_lo, e0;
        bit ok;
        rst_n = 1'b0; lock = 1'b0; restart = 1'b0;
        repeat (3) tick();
        n_tests++; if (pll_areset_out !== 1'b1) begin n_fail++; $display("FAIL reset_areset: got %b want 1", pll_areset_out); end
        n_tests++; if (stage_rst_n_out !== '0) begin n_fail++; $display("FAIL reset_stages: got %b want 0", stage_rst_n_out); end
        n_tests++; if (sys_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", sys_ready_out); end
        n_tests++; if (fault_out !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault_out); end
        n_tests++; if (retry_cnt_out !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", retry_cnt_out); end
        rst_n = 1'b1;
        e0 = cyc;
        wait_areset_fall(50, t_hi, t_lo, ok);
        n_tests++; if (!ok || t_lo - e0 != PRC) begin n_fail++; $display("FAIL reset_pll_hold: got %0d cycles want %0d", t_lo - e0, PRC); end
        g_w = t_lo;
    endtask

    task automatic test_clean_powerup();
        int l, b0e;
        bit ok;
        repeat (10) tick();
        lock = 1'b1;
        l = cyc;
        observe_release(200, ok);
        b0e = exp_bit0(g_w, l);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL clean_ready_seen: got 0 want 1"); end
        for (int k = 0; k < NS; k++) begin
            n_tests++;
            if (t_rise[k] != exp_stage(b0e, k)) begin n_fail++; $display("FAIL clean_stage%0d: got cycle %0d want %0d", k, t_rise[k], exp_stage(b0e, k)); end
        end
        n_tests++; if (t_ready != exp_ready(b0e)) begin n_fail++; $display("FAIL clean_ready: got cycle %0d want %0d", t_ready, exp_ready(b0e)); end
        n_tests++; if (order_bad) begin n_fail++; $display("FAIL clean_order: got out-of-order release want none"); end
        n_tests++; if (retry_cnt_out !== 4'd0 || fault_out !== 1'b0) begin n_fail++; $display("FAIL clean_status: got retry %0d fault %b want 0 0", retry_cnt_out, fault_out); end
    endtask

    task automatic test_lock_loss_run();
        int d, t_hi, t_lo, l, b0e;
        bit ok;
        for (int it = 0; it < 2; it++) begin
            repeat ($urandom_range(1, 20)) tick();
            lock = 1'b0;
            d = cyc;
            tick(); tick();
            n_tests++; if (stage_rst_n_out !== {NS{1'b1}} || sys_ready_out !== 1'b1) begin n_fail++; $display("FAIL loss_hold: got %b/%b want all-ones/1 at +2", stage_rst_n_out, sys_ready_out); end
            tick();
            n_tests++; if (stage_rst_n_out !== '0 || sys_ready_out !== 1'b0 || pll_areset_out !== 1'b1) begin n_fail++; $display("FAIL loss_clear: got %b/%b/%b want 0/0/1 at +3", stage_rst_n_out, sys_ready_out, pll_areset_out); end
            wait_areset_fall(50, t_hi, t_lo, ok);
            n_tests++; if (!ok || t_lo - (d + 3) != PRC) begin n_fail++; $display("FAIL loss_pll_pulse: got %0d cycles want %0d", t_lo - (d + 3), PRC); end
            n_tests++; if (retry_cnt_out !== 4'd0) begin n_fail++; $display("FAIL loss_retry: got %0d want 0", retry_cnt_out); end
            repeat ($urandom_range(0, 30)) tick();
            lock = 1'b1;
            l = cyc;
            observe_release(200, ok);
            b0e = exp_bit0(t_lo, l);
            for (int k = 0; k < NS; k++) begin
                n_tests++;
                if (t_rise[k] != exp_stage(b0e, k)) begin n_fail++; $display("FAIL loss_stage%0d: got cycle %0d want %0d", k, t_rise[k], exp_stage(b0e, k)); end
            end
            n_tests++; if (t_ready != exp_ready(b0e)) begin n_fail++; $display("FAIL loss_ready: got cycle %0d want %0d", t_ready, exp_ready(b0e)); end
        end
    endtask

    task automatic test_glitch();
        int t_hi, t_lo, l2, h, b0e;
        bit ok;
        for (int it = 0; it < 2; it++) begin
            lock = 1'b0;
            wait_areset_fall(60, t_hi, t_lo, ok);
            repeat ($urandom_range(0, 20)) tick();
            lock = 1'b1;
            h = (it == 0) ? 10 : int'($urandom_range(4, 14));
            repeat (h) tick();
            lock = 1'b0;
            tick();
            lock = 1'b1;
            l2 = cyc;
            observe_release(200, ok);
            b0e = exp_bit0(t_lo, l2);
            n_tests++; if (t_rise[0] != b0e) begin n_fail++; $display("FAIL glitch_stage0: got cycle %0d want %0d (hold %0d)", t_rise[0], b0e, h); end
            n_tests++; if (t_ready != exp_ready(b0e)) begin n_fail++; $display("FAIL glitch_ready: got cycle %0d want %0d", t_ready, exp_ready(b0e)); end
            n_tests++; if (r_at_b0 != 0 || retry_cnt_out !== 4'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d/%0d want 0", r_at_b0, retry_cnt_out); end
        end
    endtask

    task automatic test_retry_then_lock();
        int r, w1, t_hi, t_lo, l, b0, b0e, d;
        bit ok;
        r = int'($urandom_range(1, 2));
        lock = 1'b0;
        wait_areset_fall(60, t_hi, w1, ok);
        t_lo = w1;
        for (int n = 1; n <= r; n++) begin
            wait_areset_fall(300, t_hi, t_lo, ok);
            n_tests++; if (!ok || t_hi != exp_timeout(w1, n)) begin n_fail++; $display("FAIL retry_time%0d: got cycle %0d want %0d", n, t_hi, exp_timeout(w1, n)); end
            n_tests++; if (retry_cnt_out !== 4'(n) || fault_out !== 1'b0) begin n_fail++; $display("FAIL retry_count%0d: got %0d fault %b want %0d 0", n, retry_cnt_out, fault_out, n); end
        end
        repeat ($urandom_range(0, 30)) tick();
        lock = 1'b1;
        l = cyc;
        b0 = -1;
        for (int i = 0; i < 100 && b0 < 0; i++) begin
            tick();
            if (stage_rst_n_out[0] === 1'b1) b0 = cyc;
        end
        b0e = exp_bit0(t_lo, l);
        n_tests++; if (b0 != b0e) begin n_fail++; $display("FAIL retry_stage0: got cycle %0d want %0d", b0, b0e); end
        n_tests++; if (retry_cnt_out !== 4'(r)) begin n_fail++; $display("FAIL retry_kept_release: got %0d want %0d", retry_cnt_out, r); end
        repeat ($urandom_range(1, 12)) tick();
        lock = 1'b0;
        d = cyc;
        repeat (3) tick();
        n_tests++; if (stage_rst_n_out !== '0 || sys_ready_out !== 1'b0) begin n_fail++; $display("FAIL release_loss_clear: got %b/%b want 0/0 at cycle %0d", stage_rst_n_out, sys_ready_out, d + 3); end
        n_tests++; if (retry_cnt_out !== 4'(r)) begin n_fail++; $display("FAIL release_loss_retry: got %0d want %0d", retry_cnt_out, r); end
        wait_areset_fall(60, t_hi, t_lo, ok);
        repeat ($urandom_range(0, 30)) tick();
        lock = 1'b1;
        l = cyc;
        observe_release(200, ok);
        b0e = exp_bit0(t_lo, l);
        n_tests++; if (t_ready != exp_ready(b0e) || r_at_b0 != r) begin n_fail++; $display("FAIL retry_relock: got ready %0d retry %0d want %0d %0d", t_ready, r_at_b0, exp_ready(b0e), r); end
        n_tests++; if (retry_cnt_out !== 4'd0) begin n_fail++; $display("FAIL retry_clear_run: got %0d want 0", retry_cnt_out); end
    endtask

    task automatic test_never_lock();
        int t_hi, w, t_fault, prev;
        int t_ret [4];
        bit ok, stage_bad, hold_bad;
        for (int n = 0; n < 4; n++) t_ret[n] = -1;
        t_fault = -1;
        stage_bad = 1'b0;
        hold_bad = 1'b0;
        lock = 1'b0;
        wait_areset_fall(60, t_hi, w, ok);
        prev = int'(retry_cnt_out);
        for (int i = 0; i < 500 && t_fault < 0; i++) begin
            tick();
            if (int'(retry_cnt_out) != prev && retry_cnt_out <= 4'd3) t_ret[retry_cnt_out] = cyc;
            prev = int'(retry_cnt_out);
            if (fault_out === 1'b1) t_fault = cyc;
            if (stage_rst_n_out !== '0) stage_bad = 1'b1;
        end
        for (int n = 1; n <= MR; n++) begin
            n_tests++;
            if (t_ret[n] != exp_timeout(w, n)) begin n_fail++; $display("FAIL never_retry%0d: got cycle %0d want %0d", n, t_ret[n], exp_timeout(w, n)); end
        end
        n_tests++; if (t_fault != exp_timeout(w, MR)) begin n_fail++; $display("FAIL never_fault: got cycle %0d want %0d", t_fault, exp_timeout(w, MR)); end
        repeat (30) begin
            tick();
            if (pll_areset_out !== 1'b1 || stage_rst_n_out !== '0 || fault_out !== 1'b1 || retry_cnt_out !== 4'(MR)) hold_bad = 1'b1;
        end
        n_tests++; if (hold_bad || stage_bad) begin n_fail++; $display("FAIL never_hold: got hold_bad %b stage_bad %b want 0 0", hold_bad, stage_bad); end
    endtask

    task automatic test_restart_from_fault();
        int l0, n0, t_hi, w, b0e;
        bit ok;
        lock = 1'b1;
        l0 = cyc;
        repeat (5) tick();
        n_tests++; if (fault_out !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b want 1", fault_out); end
        restart = 1'b1;
        n0 = cyc;
        tick();
        restart = 1'b0;
        n_tests++; if (fault_out !== 1'b0 || retry_cnt_out !== 4'd0 || pll_areset_out !== 1'b1) begin n_fail++; $display("FAIL restart_clear: got fault %b retry %0d areset %b want 0 0 1", fault_out, retry_cnt_out, pll_areset_out); end
        wait_areset_fall(50, t_hi, w, ok);
        n_tests++; if (!ok || w != n0 + 1 + PRC) begin n_fail++; $display("FAIL restart_pll: got cycle %0d want %0d", w, n0 + 1 + PRC); end
        observe_release(200, ok);
        b0e = exp_bit0(w, l0);
        n_tests++; if (t_rise[0] != b0e || t_ready != exp_ready(b0e)) begin n_fail++; $display("FAIL restart_seq: got %0d/%0d want %0d/%0d", t_rise[0], t_ready, b0e, exp_ready(b0e)); end
        n_tests++; if (order_bad || fault_out !== 1'b0 || retry_cnt_out !== 4'd0) begin n_fail++; $display("FAIL restart_status: got order %b fault %b retry %0d", order_bad, fault_out, retry_cnt_out); end
    endtask

    task automatic test_async_reset();
        int b0, e0, t_hi, w, b0e;
        bit ok;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        b0 = -1;
        for (int i = 0; i < 100 && b0 < 0; i++) begin
            tick();
            if (stage_rst_n_out[0] === 1'b1) b0 = cyc;
        end
        n_tests++; if (b0 < 0) begin n_fail++; $display("FAIL async_pre_release: got no stage0 release want one"); end
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pll_areset_out !== 1'b1 || stage_rst_n_out !== '0 || sys_ready_out !== 1'b0) begin n_fail++; $display("FAIL async_outputs: got %b/%b/%b want 1/0/0", pll_areset_out, stage_rst_n_out, sys_ready_out); end
        n_tests++; if (fault_out !== 1'b0 || retry_cnt_out !== 4'd0) begin n_fail++; $display("FAIL async_status: got %b/%0d want 0/0", fault_out, retry_cnt_out); end
        tick(); tick();
        rst_n = 1'b1;
        e0 = cyc;
        wait_areset_fall(50, t_hi, w, ok);
        n_tests++; if (!ok || w != e0 + PRC) begin n_fail++; $display("FAIL async_pll: got cycle %0d want %0d", w, e0 + PRC); end
        observe_release(200, ok);
        b0e = exp_bit0(w, e0);
        n_tests++; if (t_rise[0] != b0e || t_ready != exp_ready(b0e)) begin n_fail++; $display("FAIL async_seq: got %0d/%0d want %0d/%0d", t_rise[0], t_ready, b0e, exp_ready(b0e)); end
    endtask

    initial begin
        rst_n = 1'b0;
        lock = 1'b0;
        restart = 1'b0;
        test_reset();
        test_clean_powerup();
        test_lock_loss_run();
        test_glitch();
        test_retry_then_lock();
        test_never_lock();
        test_restart_from_fault();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
